// File: rtl/mcp_sample_sched.sv
// Periodic conversion scheduler for the MCP SPI ADC temperature path: paces requests,
// boxcar-averages 2**AVG_LOG2 results, raises a hysteresis alarm and a sticky timeout error.
module mcp_sample_sched #(
    parameter int         SAMPLE_DIV = 500000,
    parameter int         AVG_LOG2   = 3,
    parameter logic [2:0] CHAN       = 3'd0,
    parameter logic [7:0] TH_HI      = 8'h25,
    parameter logic [7:0] TH_LO      = 8'h23,
    parameter int         TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       conv_req,
    output logic [2:0] conv_ch,
    input  logic       conv_done,
    input  logic [7:0] conv_data,
    output logic [7:0] temp,
    output logic       temp_valid,
    output logic       alarm,
    output logic       err,
    input  logic       err_clr
);
    localparam int TCW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TOW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int ACW = 8 + AVG_LOG2;
    localparam int SCW = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        REQ       = 3'd2,
        WAIT_DONE = 3'd3,
        PUBLISH   = 3'd4
    } state_t;

    state_t         state_r, state_next_s;
    logic [TCW-1:0] tick_cnt_r;
    logic [TOW-1:0] tmo_cnt_r;
    logic [ACW-1:0] acc_r;
    logic [SCW-1:0] cnt_r;
    logic           conv_req_r, temp_valid_r, alarm_r, err_r;
    logic [7:0]     temp_r;
    logic           tick_s, take_s, timeout_s, last_s;
    logic [7:0]     avg_s;

    assign tick_s  = en & (tick_cnt_r == TCW'(SAMPLE_DIV - 1));
    assign last_s  = (cnt_r == SCW'((1 << AVG_LOG2) - 1));
    assign avg_s   = acc_r[AVG_LOG2 +: 8];

    assign conv_req   = conv_req_r;
    assign conv_ch    = CHAN;
    assign temp       = temp_r;
    assign temp_valid = temp_valid_r;
    assign alarm      = alarm_r;
    assign err        = err_r;

    // Free-running tick divider, held at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (!en || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a conv_done on the final timeout cycle still counts as a completion
    always_comb begin
        state_next_s = state_r;
        take_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) state_next_s = WAIT_TICK;
                else    state_next_s = IDLE;
            end
            WAIT_TICK: begin
                if (!en)        state_next_s = IDLE;
                else if (tick_s) state_next_s = REQ;
                else            state_next_s = WAIT_TICK;
            end
            REQ: begin
                state_next_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (conv_done) begin
                    take_s = 1'b1;
                    if (last_s)   state_next_s = PUBLISH;
                    else if (!en) state_next_s = IDLE;
                    else          state_next_s = WAIT_TICK;
                end else if (tmo_cnt_r == TOW'(TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    if (en) state_next_s = WAIT_TICK;
                    else    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            PUBLISH: begin
                if (en) state_next_s = WAIT_TICK;
                else    state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Request handshake and transaction watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_req_r <= 1'b0;
            tmo_cnt_r  <= '0;
        end else begin
            if (state_r == REQ)          conv_req_r <= 1'b1;
            else if (take_s || timeout_s) conv_req_r <= 1'b0;
            else                          conv_req_r <= conv_req_r;
            if (state_r == REQ)            tmo_cnt_r <= '0;
            else if (state_r == WAIT_DONE) tmo_cnt_r <= tmo_cnt_r + 1'b1;
            else                           tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Batch accumulator; any partial batch dies in IDLE or on a timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (state_r == IDLE || state_r == PUBLISH || timeout_s) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (take_s) begin
            acc_r <= acc_r + ACW'(conv_data);
            cnt_r <= cnt_r + 1'b1;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Published result, hysteresis alarm and sticky error (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            temp_r       <= 8'd0;
            temp_valid_r <= 1'b0;
            alarm_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            temp_valid_r <= (state_r == PUBLISH);
            if (state_r == PUBLISH) begin
                temp_r <= avg_s;
                if (avg_s > TH_HI)      alarm_r <= 1'b1;
                else if (avg_s < TH_LO) alarm_r <= 1'b0;
                else                    alarm_r <= alarm_r;
            end else begin
                temp_r  <= temp_r;
                alarm_r <= alarm_r;
            end
            if (timeout_s)    err_r <= 1'b1;
            else if (err_clr) err_r <= 1'b0;
            else              err_r <= err_r;
        end
    end
endmodule

// File: tb/tb_mcp_sample_sched.sv
// Self-checking bench for mcp_sample_sched: directed and randomized batches against an
// arithmetic average/hysteresis model, plus timeout, enable-drop and async reset scenarios.
module tb_mcp_sample_sched;
    localparam int         SAMPLE_DIV = 10;
    localparam int         AVG_LOG2   = 2;
    localparam int         TIMEOUT    = 32;
    localparam int         NS         = 1 << AVG_LOG2;
    localparam logic [2:0] CHAN       = 3'd5;
    localparam logic [7:0] TH_HI      = 8'h25;
    localparam logic [7:0] TH_LO      = 8'h23;

    logic       clk = 1'b0;
    logic       rst, en, conv_done, err_clr;
    logic [7:0] conv_data;
    logic       conv_req, temp_valid, alarm, err;
    logic [2:0] conv_ch;
    logic [7:0] temp;

    int         ncmp = 0;
    int         nfail = 0;
    int         cyc = 0;
    logic [7:0] m_temp;
    logic       m_alarm;
    logic [7:0] bd [NS];
    int         rises [NS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcp_sample_sched #(
        .SAMPLE_DIV(SAMPLE_DIV), .AVG_LOG2(AVG_LOG2), .CHAN(CHAN),
        .TH_HI(TH_HI), .TH_LO(TH_LO), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .conv_req(conv_req), .conv_ch(conv_ch),
        .conv_done(conv_done), .conv_data(conv_data), .temp(temp),
        .temp_valid(temp_valid), .alarm(alarm), .err(err), .err_clr(err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (conv_req !== 1'b1 && n < 4 * SAMPLE_DIV + TIMEOUT) begin
            step();
            n++;
        end
        check("req_rise", conv_req, 1'b1);
    endtask

    // One ADC transaction: wait for the request, answer after lat cycles
    task automatic serve(input logic [7:0] d, input int lat, output int rise_cyc);
        logic held = 1'b1;
        wait_req();
        rise_cyc = cyc;
        for (int i = 1; i < lat; i++) begin
            step();
            if (conv_req !== 1'b1) held = 1'b0;
        end
        conv_data = d;
        conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        conv_data = 8'($urandom);
        check("req_held", held, 1'b1);
        check("req_drop", conv_req, 1'b0);
    endtask

    // Full batch from bd[]; model: truncated mean and hysteresis alarm
    task automatic run_batch(input int lat, input string tag);
        int sum = 0;
        for (int i = 0; i < NS; i++) begin
            serve(bd[i], lat, rises[i]);
            sum += int'(bd[i]);
        end
        m_temp = 8'(sum >> AVG_LOG2);
        if (m_temp > TH_HI)      m_alarm = 1'b1;
        else if (m_temp < TH_LO) m_alarm = 1'b0;
        check({tag, "_tv_early"}, temp_valid, 1'b0);
        step();
        check({tag, "_tv"}, temp_valid, 1'b1);
        check({tag, "_temp"}, temp, m_temp);
        check({tag, "_alarm"}, alarm, m_alarm);
        step();
        check({tag, "_tv_end"}, temp_valid, 1'b0);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NS; i++) bd[i] = v;
    endtask

    task automatic fill_rand();
        logic [7:0] base = 8'($urandom_range(30, 42));
        for (int i = 0; i < NS; i++) bd[i] = base + 8'($urandom_range(0, 6));
    endtask

    // Engine never answers: request must last TIMEOUT cycles, then err sets
    task automatic do_timeout();
        int   n = 0;
        logic tv_seen = 1'b0;
        wait_req();
        while (conv_req === 1'b1 && n < 3 * TIMEOUT) begin
            step();
            n++;
            if (temp_valid === 1'b1) tv_seen = 1'b1;
        end
        en = 1'b0;
        check("tmo_len", n, TIMEOUT);
        check("tmo_err", err, 1'b1);
        check("tmo_no_tv", tv_seen, 1'b0);
        check("tmo_temp_hold", temp, m_temp);
    endtask

    initial begin
        int   r;
        logic tv_seen;
        logic held;
        rst = 1'b1; en = 1'b0; conv_done = 1'b0; conv_data = 8'd0; err_clr = 1'b0;
        m_temp = 8'd0; m_alarm = 1'b0;
        step();
        step();
        check("rst_req", conv_req, 1'b0);
        check("rst_temp", temp, 8'd0);
        check("rst_tv", temp_valid, 1'b0);
        check("rst_alarm", alarm, 1'b0);
        check("rst_err", err, 1'b0);
        check("conv_ch", conv_ch, CHAN);
        rst = 1'b0;
        repeat (3 * SAMPLE_DIV) step();
        check("disabled_noreq", conv_req, 1'b0);

        en = 1'b1;
        bd[0] = 8'd20; bd[1] = 8'd21; bd[2] = 8'd22; bd[3] = 8'd23;
        run_batch(3, "b21");
        check("b21_const", temp, 8'd21);
        check("b21_alarm0", alarm, 1'b0);

        fill(8'h26); run_batch(2, "h26"); check("alarm_set", alarm, 1'b1);
        fill(8'h24); run_batch(4, "h24"); check("alarm_hold", alarm, 1'b1);
        fill(8'h22); run_batch(1, "h22"); check("alarm_clr", alarm, 1'b0);

        repeat (8) begin
            fill_rand();
            run_batch($urandom_range(1, 9), "rnd");
        end

        // Slow engine: ticks during a transaction must be dropped
        fill_rand();
        run_batch(25, "slow");
        for (int i = 1; i < NS; i++) check("slow_interval", (rises[i] - rises[i-1]) >= 26, 1'b1);

        do_timeout();
        repeat (5) step();
        check("err_sticky", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", err, 1'b0);
        en = 1'b1;
        do_timeout();
        step();

        // Enable dropped mid-transaction: finish it, then discard the partial batch
        en = 1'b1;
        serve(8'hF0, 2, r);
        serve(8'hF0, 2, r);
        wait_req();
        en = 1'b0;
        held = 1'b1;
        repeat (4) begin
            step();
            if (conv_req !== 1'b1) held = 1'b0;
        end
        check("endrop_held", held, 1'b1);
        conv_data = 8'hF0; conv_done = 1'b1;
        step();
        conv_done = 1'b0;
        check("endrop_reqlow", conv_req, 1'b0);
        tv_seen = 1'b0;
        repeat (3 * SAMPLE_DIV) begin
            step();
            if (temp_valid === 1'b1 || conv_req === 1'b1) tv_seen = 1'b1;
        end
        check("endrop_quiet", tv_seen, 1'b0);
        check("endrop_temp", temp, m_temp);
        en = 1'b1;
        fill_rand();
        run_batch(3, "after_drop");

        fill(8'h27); run_batch(2, "h27"); check("alarm_set2", alarm, 1'b1);

        // Async reset in WAIT_DONE
        wait_req();
        step();
        rst = 1'b1;
        #1;
        check("arst_req", conv_req, 1'b0);
        check("arst_temp", temp, 8'd0);
        check("arst_tv", temp_valid, 1'b0);
        check("arst_alarm", alarm, 1'b0);
        check("arst_err", err, 1'b0);
        m_temp = 8'd0; m_alarm = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_rand();
        run_batch(5, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
